// File: rtl/core_management_if.sv
// Shared core-management types and the AXI4-Lite bundle used for each core's register port.
package core_manage_types;
    localparam int NUM_CPUS = 2;

    typedef struct packed {
        logic [2:0] spare;
        logic       halt;
    } IO_manage_t;
endpackage

interface axi_interface;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/core_management.sv
// Per-core management registers: each core owns one AXI4-Lite port with CTRL/STATUS/SCRATCH,
// and the registered halt lines combine each core's CTRL bit0 with the global power-good.
module core_management #(
    parameter int NUM_CPUS = core_manage_types::NUM_CPUS,
    parameter int WIDTH    = $bits(core_manage_types::IO_manage_t)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwr,
    axi_interface.slave         s_axi [NUM_CPUS],
    output logic [NUM_CPUS-1:0] halt
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [NUM_CPUS-1:0] halt_req;

    for (genvar i = 0; i < NUM_CPUS; i++) begin : g_port
        w_state_t         w_state;
        r_state_t         r_state;
        logic [1:0]       aw_idx;
        logic [1:0]       wr_idx;
        logic             wr_en;
        logic [WIDTH-1:0] ctrl;
        logic [31:0]      scratch;
        logic [31:0]      status;
        logic [31:0]      rd_mux;
        logic [31:0]      rdata_q;
        logic             awready_q;
        logic             bvalid_q;
        logic             arready_q;
        logic             rvalid_q;
        logic             unused_bits;

        // Only the word index matters and every write is a full word.
        assign unused_bits = ^{s_axi[i].awaddr[31:2], s_axi[i].araddr[31:2], s_axi[i].wstrb};

        assign s_axi[i].wready = (w_state == W_DATA) || ((w_state == W_IDLE) && s_axi[i].awvalid);
        assign wr_en  = s_axi[i].wvalid && s_axi[i].wready;
        assign wr_idx = (w_state == W_IDLE) ? s_axi[i].awaddr[1:0] : aw_idx;

        assign s_axi[i].awready = awready_q;
        assign s_axi[i].bvalid  = bvalid_q;
        assign s_axi[i].bresp   = 2'b00;
        assign s_axi[i].arready = arready_q;
        assign s_axi[i].rvalid  = rvalid_q;
        assign s_axi[i].rdata   = rdata_q;
        assign s_axi[i].rresp   = 2'b00;

        assign halt_req[i] = ctrl[0];
        assign status      = {16'd0, 8'(i), 6'd0, pwr, halt[i]};

        always_ff @(posedge clk) begin
            if (rst) begin
                ctrl    <= '0;
                scratch <= '0;
            end else if (wr_en) begin
                case (wr_idx)
                    2'd0:    ctrl    <= s_axi[i].wdata[WIDTH-1:0];
                    2'd2:    scratch <= s_axi[i].wdata;
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                w_state   <= W_IDLE;
                aw_idx    <= '0;
                awready_q <= 1'b1;
                bvalid_q  <= 1'b0;
            end else begin
                case (w_state)
                    W_IDLE: begin
                        if (s_axi[i].awvalid) begin
                            aw_idx    <= s_axi[i].awaddr[1:0];
                            awready_q <= 1'b0;
                            if (s_axi[i].wvalid) begin
                                w_state  <= W_RESP;
                                bvalid_q <= 1'b1;
                            end else begin
                                w_state <= W_DATA;
                            end
                        end
                    end
                    W_DATA: begin
                        if (s_axi[i].wvalid) begin
                            w_state  <= W_RESP;
                            bvalid_q <= 1'b1;
                        end
                    end
                    W_RESP: begin
                        if (s_axi[i].bready) begin
                            w_state   <= W_IDLE;
                            bvalid_q  <= 1'b0;
                            awready_q <= 1'b1;
                        end
                    end
                    default: begin
                        w_state   <= W_IDLE;
                        awready_q <= 1'b1;
                        bvalid_q  <= 1'b0;
                    end
                endcase
            end
        end

        // Read data is captured at the AR handshake, so a same-cycle write is not visible.
        always_comb begin
            rd_mux = '0;
            case (s_axi[i].araddr[1:0])
                2'd0:    rd_mux = 32'(ctrl);
                2'd1:    rd_mux = status;
                2'd2:    rd_mux = scratch;
                default: rd_mux = '0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= R_IDLE;
                arready_q <= 1'b1;
                rvalid_q  <= 1'b0;
                rdata_q   <= '0;
            end else begin
                case (r_state)
                    R_IDLE: begin
                        if (s_axi[i].arvalid) begin
                            r_state   <= R_DATA;
                            rdata_q   <= rd_mux;
                            rvalid_q  <= 1'b1;
                            arready_q <= 1'b0;
                        end
                    end
                    R_DATA: begin
                        if (s_axi[i].rready) begin
                            r_state   <= R_IDLE;
                            rvalid_q  <= 1'b0;
                            arready_q <= 1'b1;
                        end
                    end
                    default: begin
                        r_state   <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Losing power-good halts every core regardless of what software programmed.
    always_ff @(posedge clk) begin
        if (rst) begin
            halt <= '1;
        end else begin
            halt <= {NUM_CPUS{~pwr}} | halt_req;
        end
    end

endmodule

// File: tb/tb_core_management.sv
// Self-checking bench for core_management: table of register transactions plus hand-written
// sequences, with read data checked through an expected-value queue.
module tb_core_management;
    localparam int N = core_manage_types::NUM_CPUS;
    localparam int W = $bits(core_manage_types::IO_manage_t);
    localparam logic [31:0] CTRL_MASK = 32'((64'd1 << W) - 64'd1);

    typedef struct {
        int          port;
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [N-1:0] exp_halt;
    } vec_t;

    typedef struct packed {
        logic [7:0]  port;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic pwr;
    logic [N-1:0] halt;

    logic [N-1:0] awvalid, wvalid, bready, arvalid, rready;
    logic [N-1:0] awready, wready, bvalid, arready, rvalid;
    logic [31:0]  awaddr [N];
    logic [31:0]  wdata  [N];
    logic [31:0]  araddr [N];
    logic [31:0]  rdata  [N];
    logic [1:0]   bresp  [N];
    logic [1:0]   rresp  [N];

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    vec_t vecs[16];

    axi_interface bus [N] ();

    for (genvar g = 0; g < N; g++) begin : g_bus
        assign bus[g].awaddr  = awaddr[g];
        assign bus[g].awvalid = awvalid[g];
        assign bus[g].wdata   = wdata[g];
        assign bus[g].wstrb   = 4'hF;
        assign bus[g].wvalid  = wvalid[g];
        assign bus[g].bready  = bready[g];
        assign bus[g].araddr  = araddr[g];
        assign bus[g].arvalid = arvalid[g];
        assign bus[g].rready  = rready[g];
        assign awready[g] = bus[g].awready;
        assign wready[g]  = bus[g].wready;
        assign bvalid[g]  = bus[g].bvalid;
        assign bresp[g]   = bus[g].bresp;
        assign arready[g] = bus[g].arready;
        assign rvalid[g]  = bus[g].rvalid;
        assign rdata[g]   = bus[g].rdata;
        assign rresp[g]   = bus[g].rresp;
    end

    core_management dut (
        .clk   (clk),
        .rst   (rst),
        .pwr   (pwr),
        .s_axi (bus),
        .halt  (halt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    task automatic report_timeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: handshake never happened, required within 20 cycles", name);
    endtask

    // Read data beats are compared against the queue as they are accepted.
    always @(negedge clk) begin
        #2;
        for (int p = 0; p < N; p++) begin
            if (rvalid[p] && rready[p]) begin
                if (exp_q.size() == 0) begin
                    report_timeout("unexpected_read_beat");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output("rdata_port", 32'(p), 32'(e.port));
                    check_output("rdata", rdata[p], e.data);
                    check_output("rresp", 32'(rresp[p]), 32'd0);
                end
            end
        end
    end

    task automatic axi_write(input int p, input logic [31:0] addr, input logic [31:0] data, input bit together);
        int n;
        @(negedge clk);
        awvalid[p] = 1'b1;
        awaddr[p]  = addr;
        if (together) begin
            wvalid[p] = 1'b1;
            wdata[p]  = data;
        end
        n = 0;
        #1;
        while (!awready[p] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!awready[p]) begin
            report_timeout("aw_handshake");
            awvalid[p] = 1'b0;
            wvalid[p]  = 1'b0;
            return;
        end
        if (together) check_output("wready_with_aw", 32'(wready[p]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        awvalid[p] = 1'b0;
        if (!together) begin
            wvalid[p] = 1'b1;
            wdata[p]  = data;
            n = 0;
            #1;
            while (!wready[p] && n < 20) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (!wready[p]) begin
                report_timeout("w_handshake");
                wvalid[p] = 1'b0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
        end
        wvalid[p] = 1'b0;
        #1;
        check_output("bvalid_after_w", 32'(bvalid[p]), 32'd1);
        check_output("bresp", 32'(bresp[p]), 32'd0);
    endtask

    task automatic axi_read_issue(input int p, input logic [31:0] addr, input logic [31:0] expected);
        int n;
        @(negedge clk);
        arvalid[p] = 1'b1;
        araddr[p]  = addr;
        exp_q.push_back('{port: 8'(p), data: expected});
        n = 0;
        #1;
        while (!arready[p] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!arready[p]) begin
            report_timeout("ar_handshake");
            arvalid[p] = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk);
        @(negedge clk);
        arvalid[p] = 1'b0;
    endtask

    task automatic axi_read_finish(input int p);
        int n;
        rready[p] = 1'b1;
        n = 0;
        #1;
        while (!rvalid[p] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rvalid[p]) begin
            report_timeout("r_handshake");
        end else begin
            @(posedge clk);
            #1;
            check_output("rvalid_drop", 32'(rvalid[p]), 32'd0);
        end
        rready[p] = 1'b0;
    endtask

    task automatic axi_read(input int p, input logic [31:0] addr, input logic [31:0] expected);
        axi_read_issue(p, addr, expected);
        axi_read_finish(p);
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        if (v.is_write) begin
            axi_write(v.port, v.addr, v.data, (idx % 3) == 2);
            @(posedge clk);
            #1;
            check_output("bvalid_single_pulse", 32'(bvalid[v.port]), 32'd0);
        end else begin
            axi_read(v.port, v.addr, v.data);
        end
        check_output($sformatf("halt_vec%0d", idx), 32'(halt), 32'(v.exp_halt));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        pwr = 1'b1;
        awvalid = '0; wvalid = '0; arvalid = '0; rready = '0; bready = '1;
        for (int p = 0; p < N; p++) begin
            awaddr[p] = '0; wdata[p] = '0; araddr[p] = '0;
        end

        vecs[0]  = '{0, 1'b1, 32'h0,   32'h0,              N'(2'b00)};
        vecs[1]  = '{0, 1'b1, 32'h0,   32'h1,              N'(2'b01)};
        vecs[2]  = '{0, 1'b0, 32'h1,   32'h3,              N'(2'b01)};
        vecs[3]  = '{1, 1'b0, 32'h1,   32'h102,            N'(2'b01)};
        vecs[4]  = '{0, 1'b1, 32'h0,   32'h6,              N'(2'b00)};
        vecs[5]  = '{0, 1'b0, 32'h0,   32'h6 & CTRL_MASK,  N'(2'b00)};
        vecs[6]  = '{0, 1'b1, 32'h106, 32'h12345678,       N'(2'b00)};
        vecs[7]  = '{0, 1'b0, 32'h2,   32'h12345678,       N'(2'b00)};
        vecs[8]  = '{1, 1'b0, 32'h2,   32'h0,              N'(2'b00)};
        vecs[9]  = '{0, 1'b1, 32'h3,   32'hFFFFFFFF,       N'(2'b00)};
        vecs[10] = '{0, 1'b0, 32'h3,   32'h0,              N'(2'b00)};
        vecs[11] = '{1, 1'b1, 32'h0,   32'hFFFFFFFF,       N'(2'b10)};
        vecs[12] = '{1, 1'b0, 32'h0,   32'hFFFFFFFF & CTRL_MASK, N'(2'b10)};
        vecs[13] = '{1, 1'b0, 32'h1,   32'h103,            N'(2'b10)};
        vecs[14] = '{1, 1'b1, 32'h0,   32'h0,              N'(2'b00)};
        vecs[15] = '{0, 1'b0, 32'h0,   32'h6 & CTRL_MASK,  N'(2'b00)};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_halt", 32'(halt), 32'((1 << N) - 1));
        check_output("reset_awready", 32'(awready), 32'((1 << N) - 1));
        check_output("reset_arready", 32'(arready), 32'((1 << N) - 1));
        check_output("reset_wready", 32'(wready), 32'd0);
        check_output("reset_bvalid", 32'(bvalid), 32'd0);
        check_output("reset_rvalid", 32'(rvalid), 32'd0);
        check_output("reset_rdata0", rdata[0], 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_output("halt_after_reset", 32'(halt), 32'd0);

        for (int i = 0; i < 16; i++) apply_stimulus(vecs[i], i);

        // Power-good drop overrides CTRL without disturbing it.
        @(negedge clk);
        pwr = 1'b0;
        @(posedge clk);
        #1;
        check_output("halt_pwr_low", 32'(halt), 32'((1 << N) - 1));
        axi_read(0, 32'h1, 32'h1);
        axi_read(1, 32'h1, 32'h101);
        axi_read(0, 32'h0, 32'h6 & CTRL_MASK);
        @(negedge clk);
        pwr = 1'b1;
        @(posedge clk);
        #1;
        check_output("halt_pwr_restored", 32'(halt), 32'd0);

        // Pending read held by rready=0 while the same port writes the same register.
        axi_read_issue(1, 32'h2, 32'h0);
        axi_write(1, 32'h2, 32'hDEADBEEF, 1'b1);
        repeat (2) begin
            @(negedge clk);
            #1;
            check_output("pending_rvalid", 32'(rvalid[1]), 32'd1);
            check_output("pending_rdata_stable", rdata[1], 32'h0);
        end
        @(negedge clk);
        axi_read_finish(1);
        axi_read(1, 32'h2, 32'hDEADBEEF);
        axi_read(1, 32'h3, 32'h0);
        axi_read(0, 32'h2, 32'h12345678);

        // Response held while bready is low.
        bready[0] = 1'b0;
        axi_write(0, 32'h2, 32'hA5A5A5A5, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_output("bvalid_held", 32'(bvalid[0]), 32'd1);
            check_output("awready_busy", 32'(awready[0]), 32'd0);
        end
        bready[0] = 1'b1;
        @(posedge clk);
        #1;
        check_output("bvalid_released", 32'(bvalid[0]), 32'd0);
        check_output("awready_released", 32'(awready[0]), 32'd1);
        axi_read(0, 32'h2, 32'hA5A5A5A5);

        // Reset in the middle of a write abandons it and clears the registers.
        @(negedge clk);
        awvalid[0] = 1'b1;
        awaddr[0]  = 32'h0;
        @(posedge clk);
        @(negedge clk);
        awvalid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("midreset_awready", 32'(awready[0]), 32'd1);
        check_output("midreset_bvalid", 32'(bvalid[0]), 32'd0);
        check_output("midreset_halt", 32'(halt), 32'((1 << N) - 1));
        @(negedge clk);
        rst = 1'b0;
        axi_read(0, 32'h2, 32'h0);
        axi_read(1, 32'h2, 32'h0);

        repeat (2) @(negedge clk);
        check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
